// File: rtl/program_counter_ras.sv
// Fetch program counter with PC+INC output and a circular return-address stack for calls and returns.
// Defining PC_ALIGN_CHECK_EN forces redirect targets to a 4-byte boundary and adds the misaligned pulse output.
module program_counter_ras #(
  parameter int unsigned         WIDTH        = 64,
  parameter logic [WIDTH-1:0]    RESET_VECTOR = '0,
  parameter int unsigned         INC          = 4,
  parameter int unsigned         RAS_DEPTH    = 4,
  localparam int unsigned        PTR_W        = $clog2(RAS_DEPTH),
  localparam int unsigned        CNT_W        = PTR_W + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [2:0]       PS,
  input  logic [WIDTH-1:0] in,
  input  logic             stall,
  output logic [WIDTH-1:0] PC,
  output logic [WIDTH-1:0] PC4,
  output logic [CNT_W-1:0] ras_count,
  output logic             ras_overflow,
  output logic             ras_underflow
`ifdef PC_ALIGN_CHECK_EN
  ,
  output logic             misaligned
`endif
);

  typedef enum logic [2:0] {
    PS_HOLD     = 3'b000,
    PS_INCR     = 3'b001,
    PS_LOAD     = 3'b010,
    PS_BRANCH   = 3'b011,
    PS_CALL_REL = 3'b100,
    PS_CALL_ABS = 3'b101,
    PS_RETURN   = 3'b110,
    PS_RSVD     = 3'b111
  } ps_e;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);
  localparam logic [WIDTH-1:0] INC_W    = WIDTH'(INC);

  ps_e              op;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] pc_inc;
  logic [PTR_W-1:0] top_q, top_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             push;
  logic             redirect;
  logic [WIDTH-1:0] target_raw;
  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] ras_mem [RAS_DEPTH];

  assign op     = ps_e'(PS);
  assign pc_inc = pc_q + INC_W;

`ifdef PC_ALIGN_CHECK_EN
  assign target = {target_raw[WIDTH-1:2], 2'b00};
`else
  assign target = target_raw;
`endif

  // top_q names the next free slot, so the newest entry lives at top_q-1 and a push
  // while full lands on the oldest entry.
  // NOTE: every variable driven here gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    pc_d       = pc_q;
    top_d      = top_q;
    count_d    = count_q;
    ovf_d      = ovf_q;
    unf_d      = unf_q;
    push       = 1'b0;
    redirect   = 1'b0;
    target_raw = in;
    if (!stall) begin
      unique case (op)
        PS_INCR:   pc_d = pc_inc;
        PS_LOAD:   redirect = 1'b1;
        PS_BRANCH: begin
          target_raw = pc_q + in;
          redirect   = 1'b1;
        end
        PS_CALL_REL, PS_CALL_ABS: begin
          if (op == PS_CALL_REL) target_raw = pc_q + in;
          redirect = 1'b1;
          push     = 1'b1;
          top_d    = top_q + PTR_W'(1);
          if (count_q == CNT_FULL) ovf_d = 1'b1;
          else                     count_d = count_q + CNT_W'(1);
        end
        PS_RETURN: begin
          redirect = 1'b1;
          if (count_q != '0) begin
            target_raw = ras_mem[top_q - PTR_W'(1)];
            top_d      = top_q - PTR_W'(1);
            count_d    = count_q - CNT_W'(1);
          end else begin
            unf_d = 1'b1;
          end
        end
        default: ;
      endcase
      if (redirect) pc_d = target;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_q    <= RESET_VECTOR;
      top_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      top_q   <= top_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // NOTE: stack storage has no reset; entries are only read once count_q says they were written.
  always_ff @(posedge clock) begin
    if (push) ras_mem[top_q] <= pc_inc;
  end

`ifdef PC_ALIGN_CHECK_EN
  logic mis_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) mis_q <= 1'b0;
    else        mis_q <= redirect && (target_raw[1:0] != 2'b00);
  end

  assign misaligned = mis_q;
`endif

  assign PC            = pc_q;
  assign PC4           = pc_inc;
  assign ras_count     = count_q;
  assign ras_overflow  = ovf_q;
  assign ras_underflow = unf_q;

endmodule

// File: doc/program_counter_ras.md
Name: program_counter_ras

Overview:
Parametrised successor to the LegV8 program counter. Holds the fetch PC and supplies PC and PC+INC. Supports hold, increment, absolute load, PC-relative branch, call and return. Calls and returns use a small circular return-address stack (RAS) with occupancy count and sticky overflow/underflow flags. Sits between the control unit (drives PS) and instruction memory/branch adder.

Parameters:
WIDTH, 64, PC and data width in bits
RESET_VECTOR, 0, PC value loaded on reset (WIDTH bits)
INC, 4, sequential increment in bytes
RAS_DEPTH, 4, return-address stack entries (power of 2, >=2)

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
PS  input  3  PC operation select (see Behaviour)
in  input  WIDTH  absolute target / byte offset / fallback return address
stall  input  1  1 = freeze PC and RAS this cycle, overrides PS
PC  output  WIDTH  current PC (registered)
PC4  output  WIDTH  PC + INC (combinational from PC)
ras_count  output  $clog2(RAS_DEPTH)+1  valid RAS entries
ras_overflow  output  1  sticky: push occurred while full
ras_underflow  output  1  sticky: pop occurred while empty

Behaviour:
- Reset (reset==0, asynchronous): PC=RESET_VECTOR, ras_count=0, top pointer=0, ras_overflow=0, ras_underflow=0. RAS storage contents don't-care. Release takes effect at the next rising edge.
- PC4 = PC + INC modulo 2^WIDTH; updates in the same cycle as PC.
- All updates at the rising clock edge; one-cycle latency from PS/in to PC.
- stall==1: PC, RAS, count and flags hold regardless of PS.
- PS encoding (when stall==0):
  - 000 HOLD: PC unchanged.
  - 001 INCR: PC <= PC+INC.
  - 010 LOAD: PC <= in.
  - 011 BRANCH: PC <= PC+in. in is a two's-complement byte offset; result modulo 2^WIDTH.
  - 100 CALL_REL: push PC+INC; PC <= PC+in.
  - 101 CALL_ABS: push PC+INC; PC <= in.
  - 110 RETURN: if ras_count>0, PC <= top entry, pop. If ras_count==0, PC <= in and ras_underflow <= 1.
  - 111 reserved: treated as HOLD; no RAS change.
- RAS is circular: top pointer increments on push and decrements on pop, modulo RAS_DEPTH.
- Push while ras_count==RAS_DEPTH: overwrite the oldest entry, count stays RAS_DEPTH, ras_overflow <= 1.
- Push while not full: count+1.
- Pop while empty: pointer and count unchanged.
- Pushed value is the PC+INC of the call instruction's own PC, sampled before the update.
- Flags clear only on reset.
- Wrap-around: PC = 2^WIDTH-INC with INCR gives 0. No exception raised.

Optional Feature:
PC_ALIGN_CHECK_EN
- Defined: adds output misaligned (1 bit, reset 0). Every PC load/branch/return target has bits [1:0] forced to 0 before being registered. misaligned is a registered one-cycle pulse, asserted the cycle after a non-stalled update whose unmasked target had bits [1:0]!=0.
- Undefined: no port and no masking; targets are registered verbatim.

Test Plan:
- Reset then 3 cycles PS=001 -> PC: 0,4,8,12; PC4 always PC+4. Assert reset mid-run -> PC=0 immediately, without waiting for a clock edge.
- PS=010 with in=64'h0000_0000_0000_1000, then PS=011 with in=-8 (64'hFFFF_FFFF_FFFF_FFF8) -> PC=0x1000, then 0xFF8.
- At PC=0x100, PS=100 with in=0x40 -> PC=0x140, ras_count=1. Then PS=110 -> PC=0x104, ras_count=0, no flags.
- Five CALL_ABS from PCs 0x0,0x10,0x20,0x30,0x40, each with in = current PC+0x10 -> ras_count=4, ras_overflow=1. Four RETURNs -> PC 0x44,0x34,0x24,0x14. Fifth RETURN with in=0x500 -> PC=0x500, ras_underflow=1.
- stall=1 held with PS=100 for 3 cycles -> PC, ras_count and flags unchanged. PS=111 -> PC held.
- PC=64'hFFFF_FFFF_FFFF_FFFC, PS=001 -> PC=0. With PC_ALIGN_CHECK_EN: PS=010, in=0x1002 -> PC=0x1000, misaligned pulses 1 for one cycle.
